// File: rtl/bram_acq_pkg.sv
// Shared types and constants for the BRAM acquisition sequencer.
// State encoding and the all-lanes write-enable pattern.
package bram_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_ALIGN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } acq_state_t;

    localparam logic [3:0] WEN_ALL = 4'b1111;

endpackage

// File: rtl/bram_acq_controller.sv
// Sequencer for one BRAM acquisition channel: arm, trigger,
// align to the address wrap, then write N whole frames.
module bram_acq_controller
    import bram_acq_pkg::*;
#(
    parameter int BRAM_WIDTH      = 13,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       trig_en,
    input  logic                       trigger,
    input  logic [FRAME_CNT_WIDTH-1:0] n_frames,
    input  logic [BRAM_WIDTH-1:0]      address,
    output logic [3:0]                 wen,
    output logic                       busy,
    output logic                       done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_idx,
    output logic                       first_frame
);

    localparam logic [BRAM_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_ONE =
        FRAME_CNT_WIDTH'(1);

    acq_state_t                 state;
    acq_state_t                 state_nxt;
    logic [BRAM_WIDTH-1:0]      word_cnt;
    logic [FRAME_CNT_WIDTH-1:0] frames_total;
    logic [FRAME_CNT_WIDTH-1:0] frame_nxt;
    logic                       start_ok;
    logic                       word_last;
    logic                       frame_last;
    logic                       finish;

    // Qualified events: accepted start, end of frame, end of run
    always_comb begin
        start_ok   = start && !abort &&
                     (state == ST_IDLE || state == ST_DONE);
        word_last  = (word_cnt == ADDR_LAST);
        frame_last = (frame_idx == frames_total - FRAME_ONE);
        finish     = (state == ST_WRITE) && word_last &&
                     frame_last && !abort;
    end

    // Next-state decode; abort overrides everything
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start)
                        state_nxt = trig_en ? ST_ARMED : ST_ALIGN;
                end
                ST_ARMED: begin
                    if (trigger)
                        state_nxt = ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (address == ADDR_LAST)
                        state_nxt = ST_WRITE;
                end
                ST_WRITE: begin
                    if (word_last && frame_last)
                        state_nxt = ST_DONE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Frame index: cleared on start, stepped at each inner wrap
    always_comb begin
        frame_nxt = frame_idx;
        if (start_ok)
            frame_nxt = '0;
        else if (state == ST_WRITE && !abort &&
                 word_last && !frame_last)
            frame_nxt = frame_idx + FRAME_ONE;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Word counter and latched frame total (0 requested -> 1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt     <= '0;
            frames_total <= FRAME_ONE;
        end else if (start_ok) begin
            word_cnt     <= '0;
            frames_total <= (n_frames == '0) ? FRAME_ONE : n_frames;
        end else if (state == ST_WRITE) begin
            word_cnt     <= word_cnt + BRAM_WIDTH'(1);
        end
    end

    // Registered outputs, derived from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_idx   <= '0;
            first_frame <= 1'b0;
        end else begin
            wen         <= (state_nxt == ST_WRITE) ? WEN_ALL : 4'b0000;
            busy        <= (state_nxt == ST_ARMED) ||
                           (state_nxt == ST_ALIGN) ||
                           (state_nxt == ST_WRITE);
            frame_idx   <= frame_nxt;
            first_frame <= (state_nxt == ST_WRITE) && (frame_nxt == '0);
            if (start_ok)
                done <= 1'b0;
            else if (finish)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bram_acq_controller.sv
// Self-checking bench for bram_acq_controller: table of runs
// plus hand sequences for abort, busy-start and async reset.
module tb_bram_acq_controller;
    import bram_acq_pkg::*;

    localparam int BW    = 4;
    localparam int FW    = 4;
    localparam int WORDS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          trig_en = 1'b0;
    logic          trigger = 1'b0;
    logic [FW-1:0] n_frames = '0;
    logic [BW-1:0] address = '0;
    logic [3:0]    wen;
    logic          busy;
    logic          done;
    logic [FW-1:0] frame_idx;
    logic          first_frame;

    typedef struct packed {
        logic [3:0]    wen;
        logic [BW-1:0] addr;
        logic [FW-1:0] fidx;
        logic          first;
        logic          busy;
        logic          done;
    } obs_t;

    typedef struct {
        logic [FW-1:0] n;
        logic          te;
        int            s;
        int            ta;
        int            exp_fidx;
        int            exp_words;
    } vec_t;

    obs_t sb_q[$];
    vec_t vecs[5];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   first_wen = -1;
    int   wen_hits  = 0;
    logic wen_d     = 1'b0;

    bram_acq_controller #(
        .BRAM_WIDTH     (BW),
        .FRAME_CNT_WIDTH(FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .trig_en    (trig_en),
        .trigger    (trigger),
        .n_frames   (n_frames),
        .address    (address),
        .wen        (wen),
        .busy       (busy),
        .done       (done),
        .frame_idx  (frame_idx),
        .first_frame(first_frame)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One clock: step the free-running address, then score outputs
    task automatic tick();
        obs_t got;
        obs_t e;
        @(posedge clk);
        #1;
        cyc++;
        address = BW'(address + 1);
        if (wen !== 4'h0) begin
            wen_hits++;
            if (!wen_d)
                first_wen = cyc;
            got = {wen, address, frame_idx, first_frame, busy, done};
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_wen got %0h want none (cycle %0d)",
                         got, cyc);
            end else begin
                e = sb_q.pop_front();
                check("sb_word", 32'(got), 32'(e));
            end
        end
        wen_d = (wen !== 4'h0);
    endtask

    task automatic push_frames(input logic [FW-1:0] n);
        obs_t r;
        int   nf;
        nf = (n == '0) ? 1 : int'(n);
        for (int f = 0; f < nf; f++) begin
            for (int a = 0; a < WORDS; a++) begin
                r.wen   = WEN_ALL;
                r.addr  = BW'(a);
                r.fidx  = FW'(f);
                r.first = (f == 0);
                r.busy  = 1'b1;
                r.done  = 1'b0;
                sb_q.push_back(r);
            end
        end
    endtask

    // Tick on the wrap strictly after the pulse at cycle r, address a
    function automatic int lap(input int r, input int a);
        int m;
        m = WORDS - 1 - a;
        if (m == 0)
            m = WORDS;
        return r + m + 1;
    endfunction

    task automatic wait_addr(input int a);
        int k;
        k = 0;
        while (int'(address) != a && k < 40) begin
            tick();
            k++;
        end
        check("wait_addr", 32'(address), 32'(a));
    endtask

    task automatic do_start(input logic [FW-1:0] n, input logic te,
                            input int s, output int r);
        wait_addr(s);
        n_frames  = n;
        trig_en   = te;
        start     = 1'b1;
        push_frames(n);
        first_wen = -1;
        r         = cyc;
        tick();
        start    = 1'b0;
        n_frames = n + 4'd5;
        trig_en  = !te;
    endtask

    task automatic do_trigger(input int ta, output int r);
        wait_addr(ta);
        trigger = 1'b1;
        r       = cyc;
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_wen();
        int k;
        k = 0;
        while (first_wen < 0 && k < 60) begin
            tick();
            k++;
        end
        check("wen_rise", 32'(first_wen >= 0), 32'd1);
    endtask

    task automatic wait_done(input int ef, input int nw, input int fidx);
        int k;
        k = 0;
        while (done !== 1'b1 && k < nw + 64) begin
            tick();
            k++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("first_wen_cyc", 32'(first_wen), 32'(ef));
        check("done_cyc", 32'(cyc), 32'(ef + nw));
        check("final_outs", 32'({wen, busy, frame_idx, first_frame}),
              32'({4'h0, 1'b0, FW'(fidx), 1'b0}));
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int r;
        int r2;
        int ef;
        do_start(v.n, v.te, v.s, r);
        ef = lap(r, v.s);
        if (v.te) begin
            do_trigger(v.ta, r2);
            ef = lap(r2, v.ta);
        end
        wait_done(ef, v.exp_words, v.exp_fidx);
    endtask

    initial begin
        int r;
        int r2;
        vecs[0] = '{4'd1, 1'b0, 5, 0, 0, 16};
        vecs[1] = '{4'd3, 1'b0, 9, 0, 2, 48};
        vecs[2] = '{4'd1, 1'b1, 3, 15, 0, 16};
        vecs[3] = '{4'd0, 1'b0, 15, 0, 0, 16};
        vecs[4] = '{4'd2, 1'b1, 0, 7, 1, 32};

        rst = 1'b1;
        repeat (3) tick();
        check("reset_outs",
              32'({wen, busy, done, frame_idx, first_frame}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i]);

        // Abort in frame 1 of 3, then a clean rerun
        do_start(4'd3, 1'b0, 2, r);
        wait_wen();
        while (cyc < first_wen + 20)
            tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outs", 32'({wen, busy, done}), 32'd0);
        check("abort_left", 32'(sb_q.size()), 32'd27);
        sb_q.delete();
        wen_hits = 0;
        repeat (20) tick();
        check("abort_quiet", 32'(wen_hits), 32'd0);
        run_vec('{4'd1, 1'b0, 7, 0, 0, 16});

        // Start while armed is ignored, trigger then runs 1 frame
        do_start(4'd1, 1'b1, 4, r);
        wait_addr(8);
        start    = 1'b1;
        trig_en  = 1'b0;
        n_frames = 4'd5;
        tick();
        start    = 1'b0;
        wen_hits = 0;
        repeat (20) tick();
        check("busy_start_quiet", 32'(wen_hits), 32'd0);
        check("busy_start_busy", 32'(busy), 32'd1);
        do_trigger(10, r2);
        wait_done(lap(r2, 10), 16, 0);

        // Start with abort from DONE: stay idle, done kept
        start    = 1'b1;
        abort    = 1'b1;
        trig_en  = 1'b0;
        n_frames = 4'd1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_outs", 32'({wen, busy, done}), 32'd1);
        wen_hits = 0;
        repeat (40) tick();
        check("start_abort_quiet", 32'(wen_hits), 32'd0);
        check("start_abort_idle", 32'({busy, done}), 32'd1);

        // Asynchronous reset in the middle of frame 1
        do_start(4'd2, 1'b0, 0, r);
        wait_wen();
        while (cyc < first_wen + 18)
            tick();
        check("pre_rst_frame", 32'(frame_idx), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_outs",
              32'({wen, busy, done, frame_idx, first_frame}), 32'd0);
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_outs",
              32'({wen, busy, done, frame_idx, first_frame}), 32'd0);
        run_vec('{4'd2, 1'b0, 6, 0, 1, 32});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
